// File: rtl/mux_pkg.sv
// Shared constants and types for the 2:1 selector family.
package mux_pkg;

    localparam int unsigned MUX_DEFAULT_WIDTH = 1;

    typedef logic [MUX_DEFAULT_WIDTH-1:0] data_t;

endpackage : mux_pkg

// File: rtl/mux2_comb.sv
// Pure combinational 2:1 select; shared by the direct output and the register D-input.
module mux2_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // ?: keeps the bitwise merge behaviour when s is unknown
    assign y = s ? b : a;

endmodule : mux2_comb

// File: rtl/two_x_one_mux.sv
// 2:1 datapath selector with a combinational output and a registered copy.
module two_x_one_mux
    import mux_pkg::*;
#(
    parameter int unsigned      WIDTH   = MUX_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] y_d;

    mux2_comb #(
        .WIDTH (WIDTH)
    ) u_sel (
        .a (a),
        .b (b),
        .s (s),
        .y (y_d)
    );

    assign y = y_d;

    // Registered copy; reset value applies asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= RST_VAL;
        end else begin
            y_q <= y_d;
        end
    end

endmodule : two_x_one_mux

// File: tb/tb_two_x_one_mux.sv
// Directed self-checking bench for two_x_one_mux at WIDTH=1 and WIDTH=8.
`timescale 1ns/1ps
module tb_two_x_one_mux;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;

    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       s1 = 1'b0;
    logic       y1;
    logic       yq1;

    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       s8 = 1'b0;
    logic [7:0] y8;
    logic [7:0] yq8;

    int n_checks = 0;
    int n_fail   = 0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    two_x_one_mux #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .s     (s1),
        .y     (y1),
        .y_q   (yq1)
    );

    two_x_one_mux #(
        .WIDTH   (8),
        .RST_VAL (8'h5A)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .s     (s8),
        .y     (y8),
        .y_q   (yq8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tt_exp;
        logic [2:0] v;
        tt_exp = 8'b1101_1000;

        // Reset with the clock idle
        #2 rst_n = 1'b0;
        #1;
        check("rst_yq1", 8'(yq1), 8'h00);
        check("rst_yq8", yq8, 8'h5A);

        // Truth table, reset held, no clock
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            a1 = v[2];
            b1 = v[1];
            s1 = v[0];
            #10;
            check($sformatf("tt_y_%0d", i), 8'(y1), 8'(tt_exp[i]));
            check($sformatf("tt_yq_%0d", i), 8'(yq1), 8'h00);
        end

        // X select where both inputs agree
        a1 = 1'b1; b1 = 1'b1; s1 = 1'bx;
        #1;
        check("xsel_y", 8'(y1), 8'h01);

        // Wide combinational under reset
        a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
        #1;
        check("w_s0_y", y8, 8'hA5);
        s8 = 1'b1;
        #1;
        check("w_s1_y", y8, 8'h3C);
        check("w_rst_yq", yq8, 8'h5A);

        // Release reset with clock idle, then start clocking
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b0;
        s8 = 1'b0;
        #1;
        check("rel_hold_yq1", 8'(yq1), 8'h00);
        clk_en = 1'b1;

        // Registered path
        edge_sample();
        check("reg_yq1", 8'(yq1), 8'h01);
        check("reg_yq8_a", yq8, 8'hA5);
        s1 = 1'b1;
        s8 = 1'b1;
        #1;
        check("reg_y_imm", 8'(y1), 8'h00);
        check("reg_yq_hold", 8'(yq1), 8'h01);
        check("reg_yq8_hold", yq8, 8'hA5);
        edge_sample();
        check("reg_yq_next", 8'(yq1), 8'h00);
        check("reg_yq8_b", yq8, 8'h3C);

        // Load a 1 then assert reset between edges
        s1 = 1'b0;
        edge_sample();
        check("pre_rst_yq", 8'(yq1), 8'h01);
        #1 rst_n = 1'b0;
        #1;
        check("async_yq1", 8'(yq1), 8'h00);
        check("async_yq8", yq8, 8'h5A);
        a1 = 1'b0;
        #1;
        check("async_y_a", 8'(y1), 8'h00);
        b1 = 1'b1; s1 = 1'b1;
        #1;
        check("async_y_b", 8'(y1), 8'h01);
        edge_sample();
        check("rst_held_yq1", 8'(yq1), 8'h00);
        check("rst_held_yq8", yq8, 8'h5A);

        // Release mid-cycle; first capture on the next rising edge
        a1 = 1'b1; s1 = 1'b0;
        s8 = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("rel_yq1_wait", 8'(yq1), 8'h00);
        check("rel_yq8_wait", yq8, 8'h5A);
        edge_sample();
        check("rel_yq1_cap", 8'(yq1), 8'h01);
        check("rel_yq8_cap", yq8, 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_two_x_one_mux
